// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit sequencer around the 4-bit nibble ALU:
// op codes, sequencer FSM states, per-pass op remap and op predicates.
package alu_pkg;

    localparam logic [2:0] ADD_OP = 3'd0;
    localparam logic [2:0] ADC_OP = 3'd1;
    localparam logic [2:0] SUB_OP = 3'd2;
    localparam logic [2:0] SBC_OP = 3'd3;
    localparam logic [2:0] AND_OP = 3'd4;
    localparam logic [2:0] XOR_OP = 3'd5;
    localparam logic [2:0] OR_OP  = 3'd6;
    localparam logic [2:0] CP_OP  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    // Returns {lo_op, hi_op}. The high pass always chains the low pass carry,
    // and cp becomes a plain subtract so the difference is available for Z.
    function automatic logic [5:0] remap_op(input logic [2:0] op);
        logic [5:0] r;
        case (op)
            ADD_OP:  r = {ADD_OP, ADC_OP};
            ADC_OP:  r = {ADC_OP, ADC_OP};
            SUB_OP:  r = {SUB_OP, SBC_OP};
            SBC_OP:  r = {SBC_OP, SBC_OP};
            CP_OP:   r = {SUB_OP, SBC_OP};
            default: r = {op, op};
        endcase
        return r;
    endfunction

    // Carry/borrow-producing ops (cp counts: it is a subtract internally).
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ADD_OP) || (op == ADC_OP) || (op == SUB_OP) ||
               (op == SBC_OP) || (op == CP_OP);
    endfunction

    // Ops that set the N flag.
    function automatic logic is_sub(input logic [2:0] op);
        return (op == SUB_OP) || (op == SBC_OP) || (op == CP_OP);
    endfunction

endpackage

// File: rtl/alu8_sequencer_if.sv
// Request/response bundle between CPU control and the 8-bit ALU sequencer.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_valid while req_ready is low is simply ignored
// (no queuing). done is a one-cycle pulse marking fresh result/flags, which
// then hold until the next done.
interface alu8_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cin;
    logic       done;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_n;
    logic       flag_h;
    logic       flag_c;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin,
        input  req_ready, done, result, flag_z, flag_n, flag_h, flag_c
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin,
        output req_ready, done, result, flag_z, flag_n, flag_h, flag_c
    );
endinterface

// File: rtl/alu.sv
// Existing 4-bit nibble ALU. cout is carry-out for add/adc and borrow-out for
// sub/sbc/cp; logic ops report cout=0. cp returns a unchanged.
module alu
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] y,
    output logic       cout
);

    logic [4:0] t;

    // Five-bit arithmetic so bit 4 is the carry or (two's complement) borrow.
    always_comb begin
        t    = 5'd0;
        y    = 4'd0;
        cout = 1'b0;
        case (op)
            ADD_OP: begin
                t    = {1'b0, a} + {1'b0, b};
                y    = t[3:0];
                cout = t[4];
            end
            ADC_OP: begin
                t    = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                y    = t[3:0];
                cout = t[4];
            end
            SUB_OP: begin
                t    = {1'b0, a} - {1'b0, b};
                y    = t[3:0];
                cout = t[4];
            end
            SBC_OP: begin
                t    = {1'b0, a} - {1'b0, b} - {4'd0, cin};
                y    = t[3:0];
                cout = t[4];
            end
            AND_OP: y = a & b;
            XOR_OP: y = a ^ b;
            OR_OP:  y = a | b;
            CP_OP: begin
                t    = {1'b0, a} - {1'b0, b};
                y    = a;
                cout = t[4];
            end
            default: y = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu8_sequencer.sv
// 8-bit Game Boy style ALU built from two passes through one nibble ALU:
// low nibble in LO, high nibble in HI with the low carry/borrow chained in.
// Result and Z/N/H/C are registered at the end of HI alongside a done pulse.
module alu8_sequencer
    import alu_pkg::*;
#(
    parameter int OP_W   = 3,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu8_sequencer_if.slave         bus,
    output state_t                  dbg_state
);

    state_t state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cin_q;
    logic [3:0]        lo_nib_q;
    logic              lo_carry_q;

    logic [DATA_W-1:0] result_q;
    logic              z_q, n_q, h_q, c_q;
    logic              done_q;

    logic [2:0] lo_op, hi_op;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_y;
    logic       alu_cin, alu_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: accept in IDLE, then always LO -> HI -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Nibble ALU input mux: the pass being executed selects nibbles, op and carry-in.
    always_comb begin
        {lo_op, hi_op} = remap_op(op_q);
        alu_op  = lo_op;
        alu_a   = a_q[3:0];
        alu_b   = b_q[3:0];
        alu_cin = ((op_q == ADC_OP) || (op_q == SBC_OP)) ? cin_q : 1'b0;
        if (state_q == HI) begin
            alu_op  = hi_op;
            alu_a   = a_q[7:4];
            alu_b   = b_q[7:4];
            alu_cin = is_arith(op_q) ? lo_carry_q : 1'b0;
        end
    end

    alu u_alu (
        .op   (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .cin  (alu_cin),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // Datapath registers: latch request, keep low pass, commit result and flags at HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            lo_nib_q   <= 4'd0;
            lo_carry_q <= 1'b0;
            result_q   <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            h_q        <= 1'b0;
            c_q        <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        cin_q <= bus.req_cin;
                    end
                end
                LO: begin
                    lo_nib_q   <= alu_y;
                    lo_carry_q <= alu_cout;
                end
                HI: begin
                    // cp keeps A; Z still reflects the discarded difference.
                    result_q <= (op_q == CP_OP) ? a_q : {alu_y, lo_nib_q};
                    z_q      <= ({alu_y, lo_nib_q} == 8'd0);
                    n_q      <= is_sub(op_q);
                    h_q      <= is_arith(op_q) ? lo_carry_q : (op_q == AND_OP);
                    c_q      <= is_arith(op_q) ? alu_cout : 1'b0;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_h    = h_q;
    assign bus.flag_c    = c_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/alu8_sequencer.md
Name: alu8_sequencer

Overview:
Sequences the existing 4-bit nibble ALU (`alu`) to perform 8-bit Game Boy ALU operations in two passes: low nibble first, then high nibble.
- Chains carry/borrow between the passes.
- Remaps ops per pass.
- Produces the full Z/N/H/C flag set.
- Sits between CPU decode/control and the register file/flag register; one request at a time, valid/ready handshake.

Parameters:
- OP_W, 3, width of the op code (same encoding as `alu`: add=0 adc=1 sub=2 sbc=3 and=4 xor=5 or=6 cp=7)
- DATA_W, 8, operand width; fixed at 2 nibbles, other values unsupported

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; equals (state==IDLE)
- req_op  in  3  operation code
- req_a  in  8  operand A (accumulator)
- req_b  in  8  operand B
- req_cin  in  1  current C flag, used by adc/sbc only
- done  out  1  one-cycle pulse: result and flags valid/updated
- result  out  8  8-bit result; for cp equals req_a
- flag_z  out  1  zero
- flag_n  out  1  subtract
- flag_h  out  1  half carry/borrow (bit 3 -> 4)
- flag_c  out  1  carry/borrow (bit 7 -> out)

Behaviour:
- Reset (async, rst_n low): state=IDLE, done=0, result=0x00, all flags 0, internal latches 0. req_ready=1 while in reset; req_valid is ignored until rst_n is high.
- FSM states: IDLE, LO, HI.
  - IDLE: on req_valid&&req_ready, latch op/a/b/cin, go to LO. Otherwise stay.
  - LO: drive `alu` with a[3:0], b[3:0], lo_op, in_C = cin for adc/sbc, else 0. Register lo_nib and lo_carry. Go to HI.
  - HI: drive `alu` with a[7:4], b[7:4], hi_op, in_C = lo_carry (arith ops), 0 (logic ops). On the clock edge: register result and flags, set done=1, go to IDLE.
- Op remap (lo/hi):
  - add -> add/adc
  - adc -> adc/adc
  - sub -> sub/sbc
  - sbc -> sbc/sbc
  - cp -> sub/sbc (never issue the nibble ALU's cp op)
  - and/xor/or -> same op both passes
- Flags:
  - Z = ({hi_nib,lo_nib}==0); for cp this uses the difference, not result.
  - N = 1 for sub/sbc/cp, else 0.
  - H = lo_carry for arith ops; 1 for and; 0 for xor/or.
  - C = hi carry/borrow for arith ops; 0 for logic ops.
- Result: {hi_nib,lo_nib}; for cp, result = latched a (the difference is discarded).
- Latency: accept at edge k; done high for the cycle following edge k+2. Max throughput is 1 op per 3 cycles.
- done is registered, high exactly one cycle. A new request may be accepted in that same cycle, since state is already IDLE.
- result and flags hold their values until the next done; they do not change during LO/HI.
- req_valid while not ready: ignored, no queuing. Operand changes after acceptance have no effect.
- Reset mid-operation (LO or HI): immediate abort to reset values; no done pulse for the aborted op.
- All 8 op codes are legal; there is no error state.

Decomposition:
- Shared package alu_pkg:
  - op code localparams (ADD_OP..CP_OP)
  - FSM state enum (IDLE/LO/HI)
  - remap function op -> {lo_op, hi_op}
  - predicates is_arith, is_sub
- Sub-module: the existing `alu` nibble ALU, instantiated once and shared across both passes through muxed inputs. No other sub-modules.

Test Plan:
- ADD a=0x3A b=0xC6 -> result 0x00, Z1 N0 H1 C1; done exactly 2 edges after the accept edge, one cycle wide.
- ADC a=0xE1 b=0x0F cin=1 -> 0xF1, Z0 N0 H1 C0.
- ADC same operands cin=0 -> 0xF0, H1 C0.
- SUB a=0x3E b=0x40 -> 0xFE, Z0 N1 H0 C1.
- SBC a=0x3B b=0x2A cin=1 -> 0x10, Z0 N1 H0 C0.
- CP a=0x3C b=0x2F -> result 0x3C, Z0 N1 H1 C0.
- CP a=0x55 b=0x55 -> result 0x55, Z1 N1 H0 C0.
- AND 0x5A,0x0F -> 0x0A Z0 N0 H1 C0.
- XOR 0xFF,0xFF -> 0x00 Z1 H0 C0.
- OR 0x00,0x00 with cin=1 -> 0x00 Z1 C0.
- Hold req_valid high continuously with changing operands -> accepts only when req_ready=1. Results match the operands latched at each accept; back-to-back accept occurs in the done cycle.
- Assert rst_n=0 asynchronously while in LO -> no done for the aborted op; result/flags 0 and req_ready=1 during reset. After release, ADD 0x01+0x01 -> 0x02, flags 0.
